writeback_buffer: RTL

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

---
 rtl/writeback_buffer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/writeback_buffer.sv
// Write-back victim buffer: holds evicted dirty blocks in FIFO order, coalesces
// re-evictions in place, serves miss lookups, and drains to memory one block at a time.
module writeback_buffer #(
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned WORD_WIDTH      = 32,
    parameter int unsigned BLOCK_SIZE      = 2,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned DRAIN_THRESHOLD = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_valid,
    output logic                             push_ready,
    input  logic [ADDR_WIDTH-1:0]            push_addr,
    input  logic [BLOCK_SIZE*WORD_WIDTH-1:0] push_data,
    input  logic [ADDR_WIDTH-1:0]            lookup_addr,
    output logic                             lookup_hit,
    output logic [BLOCK_SIZE*WORD_WIDTH-1:0] lookup_data,
    output logic                             mem_cs,
    output logic                             mem_rw,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [BLOCK_SIZE*WORD_WIDTH-1:0] mem_data,
    input  logic                             mem_ack,
    input  logic                             flush,
    output logic                             flush_done,
    output logic                             empty,
    output logic                             full,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE);
    localparam int unsigned DATA_W       = BLOCK_SIZE * WORD_WIDTH;
    localparam int unsigned PTR_W        = $clog2(DEPTH);
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
        ~ADDR_WIDTH'((64'd1 << OFFSET_WIDTH) - 64'd1);

    typedef enum logic {
        IDLE,
        WRITE
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   addr_d [DEPTH];
    logic [DATA_W-1:0]       data_q [DEPTH];
    logic [DATA_W-1:0]       data_d [DEPTH];
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    flushing_q, flushing_d;
    logic                    flush_done_q, flush_done_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_data_q, mem_data_d;

    logic [ADDR_WIDTH-1:0]   push_blk, look_blk;
    logic [PTR_W-1:0]        idx, coal_idx, look_idx;
    logic                    coal_hit, look_hit;
    logic                    push_fire, append, pop, drain_go;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Scan from head to tail so the newest matching entry wins.
    always_comb begin
        push_blk = push_addr & BLK_MASK;
        look_blk = lookup_addr & BLK_MASK;
        idx      = '0;
        coal_hit = 1'b0;
        coal_idx = '0;
        look_hit = 1'b0;
        look_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = PTR_W'((32'(head_q) + k) % DEPTH);
            if (valid_q[idx] && addr_q[idx] == push_blk &&
                !(state_q == WRITE && k == 0)) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
            if (valid_q[idx] && addr_q[idx] == look_blk) begin
                look_hit = 1'b1;
                look_idx = idx;
            end
        end
    end

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign count       = count_q;
    assign push_ready  = !flushing_q && (!full || coal_hit);
    assign push_fire   = push_valid && push_ready;
    assign append      = push_fire && !coal_hit;
    assign pop         = (state_q == WRITE) && mem_ack;
    assign drain_go    = (state_q == IDLE) && !empty &&
                         (count_q >= CNT_W'(DRAIN_THRESHOLD) || flushing_q);

    assign lookup_hit  = look_hit;
    assign lookup_data = look_hit ? data_q[look_idx] : '0;
    assign mem_cs      = (state_q == WRITE);
    assign mem_rw      = (state_q == WRITE);
    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign flush_done  = flush_done_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        data_d       = data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        flushing_d   = flushing_q;
        flush_done_d = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;

        if (push_fire && coal_hit) begin
            data_d[coal_idx] = push_data;
        end
        if (append) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = push_blk;
            data_d[tail_q]  = push_data;
            tail_d          = ptr_inc(tail_q);
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end
        count_d = count_q + CNT_W'(append) - CNT_W'(pop);

        case (state_q)
            IDLE: begin
                if (drain_go) begin
                    state_d    = WRITE;
                    mem_addr_d = addr_q[head_q];
                    // A same-cycle coalesce into the head must reach memory too.
                    mem_data_d = (push_fire && coal_hit && coal_idx == head_q) ?
                                 push_data : data_q[head_q];
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flushing_q) begin
            if (empty) begin
                flushing_d   = 1'b0;
                flush_done_d = 1'b1;
            end
        end else if (flush) begin
            if (empty && !append) begin
                flush_done_d = 1'b1;
            end else begin
                flushing_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            flushing_q   <= 1'b0;
            flush_done_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            flushing_q   <= flushing_d;
            flush_done_q <= flush_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule
